// File: rtl/apu_pkg.sv
// Shared APU definitions: register field layouts, noise mode encoding and the
// period/length lookup tables used by the pulse, triangle and noise voices.
package apu_pkg;

    localparam int OUT_WIDTH_DEFAULT = 4;
    localparam int VOL_WIDTH         = 4;
    localparam int LEN_WIDTH         = 8;

    typedef enum logic {
        MODE_LONG  = 1'b0,
        MODE_SHORT = 1'b1
    } noise_mode_e;

    // $400C image: halt/loop, constant-volume flag, volume or decay period
    typedef struct packed {
        logic [1:0]           unused_hi;
        logic                 halt;
        logic                 const_vol;
        logic [VOL_WIDTH-1:0] volume;
    } ctrl_reg_t;

    function automatic int period_entry(input logic [3:0] sel);
        case (sel)
            4'd0:    return 4;
            4'd1:    return 8;
            4'd2:    return 16;
            4'd3:    return 32;
            4'd4:    return 64;
            4'd5:    return 96;
            4'd6:    return 128;
            4'd7:    return 160;
            4'd8:    return 202;
            4'd9:    return 254;
            4'd10:   return 380;
            4'd11:   return 508;
            4'd12:   return 762;
            4'd13:   return 1016;
            4'd14:   return 2034;
            default: return 4068;
        endcase
    endfunction

    function automatic logic [LEN_WIDTH-1:0] length_entry(input logic [4:0] sel);
        case (sel)
            5'd0:    return 8'd10;
            5'd1:    return 8'd254;
            5'd2:    return 8'd20;
            5'd3:    return 8'd2;
            5'd4:    return 8'd40;
            5'd5:    return 8'd4;
            5'd6:    return 8'd80;
            5'd7:    return 8'd6;
            5'd8:    return 8'd160;
            5'd9:    return 8'd8;
            5'd10:   return 8'd60;
            5'd11:   return 8'd10;
            5'd12:   return 8'd14;
            5'd13:   return 8'd12;
            5'd14:   return 8'd26;
            5'd15:   return 8'd14;
            5'd16:   return 8'd12;
            5'd17:   return 8'd16;
            5'd18:   return 8'd24;
            5'd19:   return 8'd18;
            5'd20:   return 8'd48;
            5'd21:   return 8'd20;
            5'd22:   return 8'd96;
            5'd23:   return 8'd22;
            5'd24:   return 8'd192;
            5'd25:   return 8'd24;
            5'd26:   return 8'd72;
            5'd27:   return 8'd26;
            5'd28:   return 8'd16;
            5'd29:   return 8'd28;
            5'd30:   return 8'd32;
            default: return 8'd30;
        endcase
    endfunction

endpackage

// File: rtl/envelope_gen.sv
// Quarter-frame envelope unit shared by the pulse and noise voices: a restartable
// divider clocking a 15..0 decay level, optionally looping, or a constant volume.
module envelope_gen
    import apu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 quarter,
    input  logic                 start,
    input  logic                 loop,
    input  logic                 const_vol,
    input  logic [VOL_WIDTH-1:0] period,
    output logic [VOL_WIDTH-1:0] volume
);

    logic                 env_start;
    logic [VOL_WIDTH-1:0] divider;
    logic [VOL_WIDTH-1:0] decay;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            env_start <= 1'b0;
            divider   <= '0;
            decay     <= '0;
        end else begin
            if (quarter) begin
                if (env_start) begin
                    env_start <= 1'b0;
                    decay     <= '1;
                    divider   <= period;
                end else if (divider == '0) begin
                    divider <= period;
                    if (decay != '0)
                        decay <= decay - VOL_WIDTH'(1);
                    else if (loop)
                        decay <= '1;
                end else begin
                    divider <= divider - VOL_WIDTH'(1);
                end
            end
            // NOTE: last non-blocking assignment wins, so a write landing on the
            // same strobe re-arms env_start for the following quarter frame.
            if (start)
                env_start <= 1'b1;
        end
    end

    assign volume = const_vol ? period : decay;

endmodule

// File: rtl/noise_channel.sv
// NES-style noise voice: period timer, LFSR, length counter and (when
// NOISE_ENVELOPE_EN is defined) the envelope unit, feeding one mixer input.
module noise_channel
    import apu_pkg::*;
#(
    parameter int LFSR_WIDTH  = 15,
    parameter int TAP_SHORT   = 6,
    parameter int TIMER_WIDTH = 12,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_240hz,
    input  logic                 enable_120hz,
    input  logic                 channel_enable,
    input  logic [7:0]           reg_400C,
    input  logic [7:0]           reg_400E,
    input  logic [7:0]           reg_400F,
    input  logic                 reg_event,
    output logic [OUT_WIDTH-1:0] noise_out,
    output logic                 length_active
);

    localparam longint TIMER_MAX = (64'd1 << TIMER_WIDTH) - 64'd1;

    ctrl_reg_t             ctrl;
    noise_mode_e           mode;
    logic [3:0]            period_sel;
    logic [4:0]            length_sel;

    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_reload;
    logic                   timer_tick;
    logic [LFSR_WIDTH-1:0]  lfsr;
    logic                   fb;
    logic [LEN_WIDTH-1:0]   length_cnt;
    logic [VOL_WIDTH-1:0]   env_volume;
    int                     period_raw;

    assign ctrl       = ctrl_reg_t'(reg_400C);
    assign mode       = noise_mode_e'(reg_400E[7]);
    assign period_sel = reg_400E[3:0];
    assign length_sel = reg_400F[7:3];

    logic unused_reg_bits;
    assign unused_reg_bits = ^{ctrl.unused_hi, reg_400E[6:4], reg_400F[2:0]};

    // Table entries wider than the timer saturate rather than wrap.
    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        period_raw   = period_entry(period_sel);
        timer_reload = (longint'(period_raw) > TIMER_MAX) ? '1 : TIMER_WIDTH'(period_raw);
        fb           = lfsr[0] ^ ((mode == MODE_SHORT) ? lfsr[TAP_SHORT] : lfsr[1]);
    end

    // Tick lands one clock after the reload, giving a period of preset+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= '0;
            timer_tick <= 1'b0;
        end else begin
            timer_tick <= (timer == '0);
            if (timer == '0)
                timer <= timer_reload;
            else
                timer <= timer - TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_WIDTH'(1);
        else if (timer_tick)
            lfsr <= (lfsr == '0) ? LFSR_WIDTH'(1) : {fb, lfsr[LFSR_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            length_cnt <= '0;
        else if (!channel_enable)
            length_cnt <= '0;
        else if (reg_event)
            length_cnt <= length_entry(length_sel);
        else if (enable_120hz && (length_cnt != '0) && !ctrl.halt)
            length_cnt <= length_cnt - LEN_WIDTH'(1);
    end

`ifdef NOISE_ENVELOPE_EN
    envelope_gen u_envelope (
        .clk       (clk),
        .reset     (reset),
        .quarter   (enable_240hz),
        .start     (reg_event),
        .loop      (ctrl.halt),
        .const_vol (ctrl.const_vol),
        .period    (ctrl.volume),
        .volume    (env_volume)
    );
`else
    // Without the envelope the raw volume field drives the output directly.
    assign env_volume = ctrl.volume;

    logic unused_env_inputs;
    assign unused_env_inputs = ^{enable_240hz, ctrl.const_vol};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            noise_out     <= '0;
            length_active <= 1'b0;
        end else begin
            noise_out     <= ((length_cnt == '0) || lfsr[0]) ? '0 : OUT_WIDTH'(env_volume);
            length_active <= (length_cnt != '0);
        end
    end

endmodule

// File: tb/tb_noise_channel.sv
// Self-checking bench for noise_channel: random timer/LFSR trials against a
// sequence model, directed length-counter cases, and envelope decay curves.
module tb_noise_channel;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       channel_enable;
    logic [7:0] reg_400C;
    logic [7:0] reg_400E;
    logic [7:0] reg_400F;
    logic       reg_event;
    logic [3:0] noise_out;
    logic       length_active;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    noise_channel dut (
        .clk            (clk),
        .reset          (reset),
        .enable_240hz   (enable_240hz),
        .enable_120hz   (enable_120hz),
        .channel_enable (channel_enable),
        .reg_400C       (reg_400C),
        .reg_400E       (reg_400E),
        .reg_400F       (reg_400F),
        .reg_event      (reg_event),
        .noise_out      (noise_out),
        .length_active  (length_active)
    );

    function automatic int period_of(input int sel);
        int tbl[16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068};
        return tbl[sel] + 1;
    endfunction

    function automatic int len_of(input int sel);
        int tbl[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
        return tbl[sel];
    endfunction

    // 15-bit Fibonacci step: feedback into bit 14, tap bit 1 (long) or 6 (short)
    function automatic int lfsr_next(input int s, input int mode);
        int tap;
        int fb;
        if (s == 0) return 1;
        tap = (mode != 0) ? ((s >> 6) & 1) : ((s >> 1) & 1);
        fb  = (s & 1) ^ tap;
        return (s >> 1) | (fb << 14);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable_240hz   = 1'b0;
        enable_120hz   = 1'b0;
        channel_enable = 1'b1;
        reg_event      = 1'b0;
    endtask

    // Edge 1 after reset release reloads the timer, so shifts fall on edges 2, 2+P, ...
    task automatic run_trial(input int sel, input int mode, input int vol,
                             input int const_bit, input int last_edge);
        int cur;
        int prev;
        int p;
        idle_inputs();
        reset    = 1'b1;
        reg_400C = {2'b00, 1'b1, const_bit[0], vol[3:0]};
        reg_400E = {mode[0], 3'b000, sel[3:0]};
        reg_400F = {5'd1, 3'b000};
        step(2);
        reset     = 1'b0;
        reg_event = 1'b1;
        step(1);
        reg_event = 1'b0;
        p   = period_of(sel);
        cur = 1;
        for (int e = 2; e <= last_edge; e++) begin
            step(1);
            prev = cur;
            if ((e - 2) % p == 0) cur = lfsr_next(cur, mode);
            check("lfsr_state", 32'(dut.lfsr), cur);
            check("noise_out", 32'(noise_out), ((prev & 1) != 0) ? 0 : vol);
            check("len_active_play", 32'(length_active), 1);
        end
    endtask

`ifdef NOISE_ENVELOPE_EN
    // Decay after n strobes of a freshly started envelope with period 2
    function automatic int decay_after(input int n, input int loop);
        int k;
        k = (n - 1) / 3;
        if (loop != 0) return 15 - (k % 16);
        return (k >= 15) ? 0 : 15 - k;
    endfunction

    task automatic run_envelope(input int loop);
        idle_inputs();
        reset    = 1'b1;
        reg_400C = {2'b00, loop[0], 1'b0, 4'd2};
        step(1);
        reset     = 1'b0;
        reg_event = 1'b1;
        step(1);
        reg_event = 1'b0;
        for (int n = 1; n <= 52; n++) begin
            enable_240hz = 1'b1;
            step(1);
            enable_240hz = 1'b0;
            step($urandom_range(0, 1));
            check(loop != 0 ? "env_loop" : "env_once", 32'(dut.env_volume), decay_after(n, loop));
        end
    endtask
`endif

    initial begin
        int sel;
        int mode;
        int vol;
        int cbit;

        idle_inputs();
        reset    = 1'b1;
        reg_400C = 8'h00;
        reg_400E = 8'h00;
        reg_400F = 8'h00;
        step(2);
        check("rst_noise_out", 32'(noise_out), 0);
        check("rst_len_active", 32'(length_active), 0);
        check("rst_lfsr", 32'(dut.lfsr), 1);

        // Long mode, fastest period, constant volume 9
        run_trial(0, 0, 9, 1, 400);

        // Reset in the middle of play clears everything on the next edge
        reset = 1'b1;
        step(1);
        check("midrst_noise_out", 32'(noise_out), 0);
        check("midrst_len_active", 32'(length_active), 0);
        check("midrst_lfsr", 32'(dut.lfsr), 1);
        reset = 1'b0;

        // Short mode: the sequence from seed 1 returns to 1 after 93 shifts
        run_trial(0, 1, 9, 1, 2 + 92 * 5);
        check("short_period93", 32'(dut.lfsr), 1);

        for (int t = 0; t < 4; t++) begin
            sel  = $urandom_range(0, 5);
            mode = $urandom_range(0, 1);
            vol  = $urandom_range(1, 15);
`ifdef NOISE_ENVELOPE_EN
            cbit = 1;
`else
            cbit = $urandom_range(0, 1);
`endif
            run_trial(sel, mode, vol, cbit, 300);
        end

        // Length counter: load 254, count down on half-frame strobes
        idle_inputs();
        reset    = 1'b1;
        reg_400C = {2'b00, 1'b0, 1'b1, 4'd5};
        reg_400E = 8'h00;
        reg_400F = {5'd1, 3'b000};
        step(1);
        reset     = 1'b0;
        reg_event = 1'b1;
        step(1);
        reg_event = 1'b0;
        check("len_load", 32'(dut.length_cnt), 254);
        for (int k = 1; k <= 253; k++) begin
            enable_120hz = 1'b1;
            step(1);
            enable_120hz = 1'b0;
            step($urandom_range(0, 2));
            check("len_count", 32'(dut.length_cnt), 254 - k);
        end
        step(1);
        check("len_active_last", 32'(length_active), 1);
        enable_120hz = 1'b1;
        step(1);
        enable_120hz = 1'b0;
        step(1);
        check("len_zero", 32'(dut.length_cnt), 0);
        check("len_active_fall", 32'(length_active), 0);
        enable_120hz = 1'b1;
        step(1);
        enable_120hz = 1'b0;
        check("len_no_wrap", 32'(dut.length_cnt), 0);

        // Halt holds the count
        reg_400C[5] = 1'b1;
        reg_event   = 1'b1;
        step(1);
        reg_event = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enable_120hz = 1'b1;
            step(1);
            enable_120hz = 1'b0;
        end
        check("len_halt", 32'(dut.length_cnt), 254);

        // Load and half-frame strobe together: load wins, no decrement
        reg_400C[5] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            sel          = $urandom_range(0, 31);
            reg_400F     = {sel[4:0], 3'b000};
            reg_event    = 1'b1;
            enable_120hz = 1'b1;
            step(1);
            reg_event    = 1'b0;
            enable_120hz = 1'b0;
            check("len_load_vs_dec", 32'(dut.length_cnt), len_of(sel));
        end

        // Channel disable clears at once and blocks reloads
        channel_enable = 1'b0;
        step(1);
        check("len_disable", 32'(dut.length_cnt), 0);
        step(1);
        check("len_disable_active", 32'(length_active), 0);
        reg_event = 1'b1;
        step(1);
        reg_event = 1'b0;
        check("len_disable_load", 32'(dut.length_cnt), 0);
        channel_enable = 1'b1;

`ifdef NOISE_ENVELOPE_EN
        run_envelope(0);
        run_envelope(1);
        // Restart coinciding with a strobe is taken on the following strobe
        reg_event    = 1'b1;
        enable_240hz = 1'b1;
        step(1);
        reg_event = 1'b0;
        step(1);
        step(1);
        enable_240hz = 1'b0;
        check("env_restart", 32'(dut.env_volume), 15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
